// File: rtl/rx_66b_decode32.sv
// rx_66b_decode32: receive PCS stage between the GTH synchronous gearbox and
// the XGMII consumer. Acquires 64b/66b block lock with gearbox slip requests,
// descrambles the payload (x^58 + x^39 + 1) and decodes each 64-bit block into
// two 32-bit XGMII words that follow the gearbox data-valid cadence.
module rx_66b_decode32 #(
  parameter int LOCK_CNT     = 64,
  parameter int BAD_LIMIT    = 16,
  parameter int SLIP_WAIT    = 32,
  parameter bit DESCR_BYPASS = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] rx_data_i,
  input  logic [1:0]  rx_header_i,
  input  logic        rx_header_v_i,
  input  logic        rx_data_v_i,
  output logic        rx_slip_o,
  output logic        block_lock_o,
  output logic [31:0] bad_hdr_cnt_o,
  output logic [31:0] xgmii_d_o,
  output logic [3:0]  xgmii_c_o,
  output logic        xgmii_v_o
);

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CNT - 1);
  localparam logic [15:0] BAD_LAST  = 16'(BAD_LIMIT - 1);
  localparam logic [15:0] WAIT_LAST = 16'(SLIP_WAIT - 1);
  localparam logic [63:0] IDLE_BLK  = {8{8'h07}};
  localparam logic [63:0] ERR_BLK   = {8{8'hFE}};

  typedef enum logic [1:0] {HUNT, WAIT_SLIP, LOCKED} lock_state_t;

  lock_state_t state, state_next;
  logic [15:0] good_cnt, good_next;
  logic [15:0] bad_cnt, bad_next;
  logic [15:0] win_cnt, win_next;
  logic [15:0] wait_cnt, wait_next;
  logic        slip_next;
  logic        bad_hdr_inc;

  logic [57:0] scr_state, scr_state_next;
  logic [31:0] descr_data;

  logic        prev_hdr;
  logic        hdr_word;
  logic        hdr_ok;
  logic        second_word;
  logic [31:0] lo_q;
  logic [1:0]  hdr_q;
  logic        hdr_bad_q;
  logic [31:0] hi_d;
  logic [3:0]  hi_c;

  logic [63:0] block;
  logic [63:0] payload;
  logic [63:0] dec_d;
  logic [7:0]  dec_c;
  logic        is_term;
  int          term_lanes;

  // A header is good only if it is 01/10 and the previous valid word was not also a header word.
  assign hdr_word    = rx_data_v_i && rx_header_v_i;
  assign hdr_ok      = (rx_header_i[0] ^ rx_header_i[1]) && !prev_hdr;
  assign second_word = rx_data_v_i && prev_hdr && !rx_header_v_i;
  assign block       = {descr_data, lo_q};
  assign payload     = {8'h00, block[63:8]};
  assign block_lock_o = (state == LOCKED);

  // Self-synchronous descrambler: each received scrambled bit, bit 0 first, is shifted into the state.
  always_comb begin
    scr_state_next = scr_state;
    descr_data     = '0;
    for (int i = 0; i < 32; i++) begin
      descr_data[i]  = rx_data_i[i] ^ scr_state_next[38] ^ scr_state_next[57];
      scr_state_next = {scr_state_next[56:0], rx_data_i[i]};
    end
    if (DESCR_BYPASS) descr_data = rx_data_i;
  end

  // Descrambler state advances only on valid gearbox words.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) scr_state <= '0;
    else if (rx_data_v_i) scr_state <= scr_state_next;
  end

  // Lock FSM next state: header counting in HUNT, slip back-off in WAIT, windowed bad count in LOCKED.
  always_comb begin
    state_next  = state;
    good_next   = good_cnt;
    bad_next    = bad_cnt;
    win_next    = win_cnt;
    wait_next   = wait_cnt;
    slip_next   = 1'b0;
    bad_hdr_inc = 1'b0;
    if (rx_data_v_i) begin
      case (state)
        HUNT: begin
          if (hdr_word) begin
            if (hdr_ok) begin
              if (good_cnt == LOCK_LAST) begin
                state_next = LOCKED;
                good_next  = '0;
                bad_next   = '0;
                win_next   = '0;
              end else begin
                good_next = good_cnt + 16'd1;
              end
            end else begin
              slip_next  = 1'b1;
              good_next  = '0;
              wait_next  = '0;
              state_next = WAIT_SLIP;
            end
          end
        end
        WAIT_SLIP: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_next  = '0;
            state_next = HUNT;
          end else begin
            wait_next = wait_cnt + 16'd1;
          end
        end
        LOCKED: begin
          if (hdr_word) begin
            if (!hdr_ok) bad_hdr_inc = 1'b1;
            if (!hdr_ok && bad_cnt == BAD_LAST) begin
              slip_next  = 1'b1;
              state_next = WAIT_SLIP;
              wait_next  = '0;
              bad_next   = '0;
              win_next   = '0;
            end else if (win_cnt == LOCK_LAST) begin
              win_next = '0;
              bad_next = '0;
            end else begin
              win_next = win_cnt + 16'd1;
              if (!hdr_ok) bad_next = bad_cnt + 16'd1;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Lock FSM state and counters; the slip request is a single-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= HUNT;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      win_cnt   <= '0;
      wait_cnt  <= '0;
      rx_slip_o <= 1'b0;
    end else begin
      rx_slip_o <= slip_next;
      if (rx_data_v_i) begin
        state    <= state_next;
        good_cnt <= good_next;
        bad_cnt  <= bad_next;
        win_cnt  <= win_next;
        wait_cnt <= wait_next;
      end
    end
  end

  // Saturating count of invalid headers observed while locked.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) bad_hdr_cnt_o <= '0;
    else if (bad_hdr_inc && bad_hdr_cnt_o != 32'hFFFF_FFFF) bad_hdr_cnt_o <= bad_hdr_cnt_o + 32'd1;
  end

  // Block decode of the assembled 64-bit block, evaluated in the cycle its second half arrives.
  always_comb begin
    dec_d      = IDLE_BLK;
    dec_c      = 8'hFF;
    is_term    = 1'b0;
    term_lanes = 0;
    if (state != LOCKED) begin
      dec_d = IDLE_BLK;
    end else if (hdr_bad_q) begin
      dec_d = ERR_BLK;
    end else if (hdr_q == 2'b01) begin
      dec_d = block;
      dec_c = 8'h00;
    end else begin
      case (block[7:0])
        8'h1E: begin
          for (int k = 0; k < 8; k++)
            if (block[8+7*k +: 7] != 7'h00) dec_d[8*k +: 8] = 8'hFE;
        end
        8'h78: begin
          dec_d = {block[63:8], 8'hFB};
          dec_c = 8'h01;
        end
        8'h33: begin
          dec_d = {block[63:40], 8'hFB, 32'h07070707};
          dec_c = 8'h1F;
        end
        8'h87: begin is_term = 1'b1; term_lanes = 0; end
        8'h99: begin is_term = 1'b1; term_lanes = 1; end
        8'hAA: begin is_term = 1'b1; term_lanes = 2; end
        8'hB4: begin is_term = 1'b1; term_lanes = 3; end
        8'hCC: begin is_term = 1'b1; term_lanes = 4; end
        8'hD2: begin is_term = 1'b1; term_lanes = 5; end
        8'hE1: begin is_term = 1'b1; term_lanes = 6; end
        8'hFF: begin is_term = 1'b1; term_lanes = 7; end
        8'h4B: dec_d = IDLE_BLK;
        default: dec_d = ERR_BLK;
      endcase
      if (is_term) begin
        for (int k = 0; k < 8; k++) begin
          if (k < term_lanes) begin
            dec_d[8*k +: 8] = payload[8*k +: 8];
            dec_c[k]        = 1'b0;
          end else if (k == term_lanes) begin
            dec_d[8*k +: 8] = 8'hFD;
          end
        end
      end
    end
  end

  // Block assembly and output staging: low half leaves with the second word, high half with the next.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_hdr  <= 1'b0;
      lo_q      <= '0;
      hdr_q     <= 2'b00;
      hdr_bad_q <= 1'b0;
      hi_d      <= 32'h07070707;
      hi_c      <= 4'hF;
      xgmii_d_o <= 32'h07070707;
      xgmii_c_o <= 4'hF;
      xgmii_v_o <= 1'b0;
    end else begin
      xgmii_v_o <= rx_data_v_i;
      if (rx_data_v_i) begin
        prev_hdr <= rx_header_v_i;
        if (rx_header_v_i) begin
          lo_q      <= descr_data;
          hdr_q     <= rx_header_i;
          hdr_bad_q <= !hdr_ok;
        end
        if (second_word) begin
          xgmii_d_o <= dec_d[31:0];
          xgmii_c_o <= dec_c[3:0];
          hi_d      <= dec_d[63:32];
          hi_c      <= dec_c[7:4];
        end else begin
          xgmii_d_o <= hi_d;
          xgmii_c_o <= hi_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_66b_decode32.sv
// tb_rx_66b_decode32: directed bench for rx_66b_decode32. Blocks are scrambled
// by a local transmit-side scrambler model and sent as header/payload half-words;
// decoded XGMII words are compared against hand-computed constants.
module tb_rx_66b_decode32;

  localparam logic [63:0] IDLE_BLK = 64'h000000000000001E;
  localparam logic [35:0] IDLE_OUT = {4'hF, 32'h07070707};
  localparam logic [35:0] ERR_OUT  = {4'hF, 32'hFEFEFEFE};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] rx_data = '0;
  logic [1:0]  rx_header = '0;
  logic        rx_header_v = 1'b0;
  logic        rx_data_v = 1'b0;
  logic        rx_slip;
  logic        block_lock;
  logic [31:0] bad_hdr_cnt;
  logic [31:0] xgmii_d;
  logic [3:0]  xgmii_c;
  logic        xgmii_v;

  int          checks = 0;
  int          errors = 0;
  int          slip_cycles = 0;
  int          locked_hdrs = 0;
  logic [57:0] tx_scr = '0;
  logic [35:0] prev_hi;
  logic [35:0] cur_lo;
  logic [63:0] gap_scr;

  always #5 clk = ~clk;

  rx_66b_decode32 #(
    .LOCK_CNT(64), .BAD_LIMIT(16), .SLIP_WAIT(32), .DESCR_BYPASS(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rx_data_i(rx_data),
    .rx_header_i(rx_header),
    .rx_header_v_i(rx_header_v),
    .rx_data_v_i(rx_data_v),
    .rx_slip_o(rx_slip),
    .block_lock_o(block_lock),
    .bad_hdr_cnt_o(bad_hdr_cnt),
    .xgmii_d_o(xgmii_d),
    .xgmii_c_o(xgmii_c),
    .xgmii_v_o(xgmii_v)
  );

  // Count clock cycles during which a slip request is high.
  always @(posedge clk) if (rx_slip === 1'b1) slip_cycles++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic hv, input logic [1:0] h, input logic [31:0] d);
    rx_data_v   = 1'b1;
    rx_header_v = hv;
    rx_header   = h;
    rx_data     = d;
    @(posedge clk);
    #1;
    rx_data_v   = 1'b0;
  endtask

  task automatic scramble64(input logic [63:0] p, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i]   = p[i] ^ tx_scr[38] ^ tx_scr[57];
      tx_scr = {tx_scr[56:0], s[i]};
    end
  endtask

  task automatic sendBlock(input logic [1:0] h, input logic [63:0] p);
    logic [63:0] s;
    scramble64(p, s);
    applyStimulus(1'b1, h, s[31:0]);
    prev_hi = {xgmii_c, xgmii_d};
    applyStimulus(1'b0, 2'b00, s[63:32]);
    cur_lo = {xgmii_c, xgmii_d};
    locked_hdrs++;
  endtask

  initial begin
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_lock", block_lock, 1'b0);
    checkOutput("rst_slip", rx_slip, 1'b0);
    checkOutput("rst_badcnt", bad_hdr_cnt, 32'd0);
    checkOutput("rst_v", xgmii_v, 1'b0);
    checkOutput("rst_out", {xgmii_c, xgmii_d}, IDLE_OUT);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_hold_out", {xgmii_c, xgmii_d}, IDLE_OUT);

    // Initial lock acquisition: 64 good headers
    for (int i = 0; i < 63; i++) sendBlock(2'b10, IDLE_BLK);
    checkOutput("lock_after_63", block_lock, 1'b0);
    checkOutput("v_normal", xgmii_v, 1'b1);
    sendBlock(2'b10, IDLE_BLK);
    checkOutput("lock_after_64", block_lock, 1'b1);
    checkOutput("no_slip_on_lock", slip_cycles, 0);
    locked_hdrs = 0;

    // Decode of the block types
    sendBlock(2'b01, 64'h0123456789ABCDEF);
    checkOutput("data_lo", cur_lo, {4'h0, 32'h89ABCDEF});
    sendBlock(2'b10, 64'hDEADBEEF12345655);
    checkOutput("data_hi", prev_hi, {4'h0, 32'h01234567});
    checkOutput("unk_lo", cur_lo, ERR_OUT);
    sendBlock(2'b10, 64'h5555555555555578);
    checkOutput("unk_hi", prev_hi, ERR_OUT);
    checkOutput("start_lo", cur_lo, {4'h1, 32'h555555FB});
    sendBlock(2'b01, 64'hD555555555555555);
    checkOutput("start_hi", prev_hi, {4'h0, 32'h55555555});
    checkOutput("data2_lo", cur_lo, {4'h0, 32'h55555555});
    sendBlock(2'b10, 64'h00000000CCBBAAB4);
    checkOutput("data2_hi", prev_hi, {4'h0, 32'hD5555555});
    checkOutput("term3_lo", cur_lo, {4'h8, 32'hFDCCBBAA});
    sendBlock(2'b10, 64'hAABBCC0000000033);
    checkOutput("term3_hi", prev_hi, IDLE_OUT);
    checkOutput("start4_lo", cur_lo, IDLE_OUT);
    sendBlock(2'b10, 64'h00000000000F001E);
    checkOutput("start4_hi", prev_hi, {4'h1, 32'hAABBCCFB});
    checkOutput("ctrl_lo", cur_lo, {4'hF, 32'h0707FE07});
    sendBlock(2'b10, 64'h0000000000000087);
    checkOutput("ctrl_hi", prev_hi, IDLE_OUT);
    checkOutput("term0_lo", cur_lo, {4'hF, 32'h070707FD});

    // Pause cycle in the middle of a block
    scramble64(64'hCAFEF00D12345678, gap_scr);
    applyStimulus(1'b1, 2'b01, gap_scr[31:0]);
    checkOutput("term0_hi", {xgmii_c, xgmii_d}, IDLE_OUT);
    rx_data_v   = 1'b0;
    rx_header_v = 1'b1;
    rx_header   = 2'b00;
    rx_data     = $urandom;
    @(posedge clk);
    #1;
    checkOutput("gap_v", xgmii_v, 1'b0);
    checkOutput("gap_hold", {xgmii_c, xgmii_d}, IDLE_OUT);
    applyStimulus(1'b0, 2'b00, gap_scr[63:32]);
    checkOutput("gap_lo", {xgmii_c, xgmii_d}, {4'h0, 32'h12345678});
    locked_hdrs++;
    sendBlock(2'b10, IDLE_BLK);
    checkOutput("gap_hi", prev_hi, {4'h0, 32'hCAFEF00D});

    // 15 bad headers in one window keep lock
    for (int i = 0; i < 15; i++) begin
      sendBlock(2'b00, IDLE_BLK);
      if (i == 0) checkOutput("bad_hdr_lo", cur_lo, ERR_OUT);
    end
    checkOutput("lock_after_15_bad", block_lock, 1'b1);
    checkOutput("badcnt_15", bad_hdr_cnt, 32'd15);
    checkOutput("no_slip_15_bad", slip_cycles, 0);

    // Move to a window start, then 16 bad headers drop lock
    while (locked_hdrs % 64 != 0) sendBlock(2'b10, IDLE_BLK);
    for (int i = 0; i < 15; i++) sendBlock(2'b11, IDLE_BLK);
    checkOutput("lock_after_15_of_16", block_lock, 1'b1);
    sendBlock(2'b00, IDLE_BLK);
    checkOutput("lock_dropped", block_lock, 1'b0);
    checkOutput("slip_on_drop", slip_cycles, 1);
    checkOutput("badcnt_31", bad_hdr_cnt, 32'd31);

    // 32 words after a slip are ignored; the next bad header in HUNT slips again
    for (int i = 0; i < 16; i++) begin
      sendBlock(2'b11, IDLE_BLK);
      if (i == 0) checkOutput("unlocked_out", cur_lo, IDLE_OUT);
    end
    checkOutput("wait_ignores_bad", slip_cycles, 1);
    sendBlock(2'b00, IDLE_BLK);
    checkOutput("hunt_slip", slip_cycles, 2);

    // Relock: 32 ignored words then 64 good headers
    for (int i = 0; i < 16 + 63; i++) sendBlock(2'b01, 64'h0);
    checkOutput("relock_after_63", block_lock, 1'b0);
    sendBlock(2'b01, 64'h0);
    checkOutput("relock_after_64", block_lock, 1'b1);
    checkOutput("slip_total", slip_cycles, 2);
    checkOutput("badcnt_unlocked", bad_hdr_cnt, 32'd31);

    // Asynchronous reset in the middle of a block
    applyStimulus(1'b1, 2'b10, 32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out", {xgmii_c, xgmii_d}, IDLE_OUT);
    checkOutput("midreset_v", xgmii_v, 1'b0);
    checkOutput("midreset_lock", block_lock, 1'b0);
    checkOutput("midreset_badcnt", bad_hdr_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
